stream_gen: RTL and testbench
=============================

// Module: stream_gen
// PURPOSE
//   Arithmetic-sequence stream source: accepts one command (start, step, count) and emits
//   count words start, start+step, start+2*step, ... on a valid/ready output stream.
//   Drives din of the stream-statistics blocks (e.g. second-largest tracker) in benches and
//   datapaths; one command in flight at a time, new command accepted only when idle.
// PARAMETERS
//   DATA_WIDTH  32  width of cmd_start, cmd_step, dout
//   CNT_WIDTH   16  width of cmd_count; max sequence length 2**CNT_WIDTH-1
// PORTS
//   clk        in   1           clock, all state updates on posedge
//   resetn     in   1           synchronous reset, active-low
//   cmd_valid  in   1           command present
//   cmd_ready  out  1           command accepted when cmd_valid && cmd_ready
//   cmd_start  in   DATA_WIDTH  first output word
//   cmd_step   in   DATA_WIDTH  increment between words (unsigned, wraps)
//   cmd_count  in   CNT_WIDTH   number of words to emit
//   out_valid  out  1           dout/out_last valid
//   out_ready  in   1           sink accepts word when out_valid && out_ready
//   dout       out  DATA_WIDTH  current sequence word
//   out_last   out  1           current word is final word of the command
//   busy       out  1           sequence in progress (state RUN)
// BEHAVIOUR
//   - Reset (resetn==0 at posedge): state=IDLE, out_valid=0, dout=0, out_last=0, busy=0,
//     remaining=0, step reg=0. cmd_ready=0 while resetn low; 1 in IDLE otherwise.
//   - States: IDLE, RUN. cmd_ready = resetn && (state==IDLE); busy = (state==RUN).
//   - IDLE: on cmd accept with cmd_count!=0 -> RUN; next cycle out_valid=1, dout=cmd_start,
//     remaining=cmd_count (1-cycle latency accept->first word). cmd_count==0: command
//     consumed, stay IDLE, no output.
//   - RUN: out_valid=1 continuously; dout/out_last held stable while out_ready==0.
//   - RUN transfer (out_ready=1): remaining>1 -> dout<=dout+step (mod 2**DATA_WIDTH,
//     carry dropped), remaining<=remaining-1; remaining==1 -> IDLE, out_valid<=0 next cycle.
//   - out_last = out_valid && (remaining==1).
//   - Back-to-back: cmd_ready rises the cycle after the last transfer; no same-cycle overlap.
//     Minimum one idle bubble between commands.
//   - cmd_valid in RUN is ignored (cmd_ready=0); command fields sampled only on accept.
//   - Reset mid-sequence: abort immediately, outputs to reset values next cycle, no last.
//   - out_ready while out_valid==0: no effect.
// TESTING
//   1. start=5, step=2, count=3, out_ready=1 -> dout 5,7,9 on 3 consecutive cycles,
//      out_last only with 9, cmd_ready high the cycle after.
//   2. Same cmd, out_ready toggled 1,0,0,1,1 -> dout=7 held stable 3 cycles, no word lost
//      or duplicated, sink sees exactly 5,7,9.
//   3. DATA_WIDTH=8, start=8'hFE, step=1, count=4 -> FE,FF,00,01; step=8'hFF from 3,
//      count 3 -> 03,02,01 (wrap arithmetic).
//   4. count=0 -> cmd accepted, out_valid stays 0, busy stays 0; following count=1, start=42
//      -> single word 42 with out_last=1.
//   5. New cmd_valid asserted during RUN -> ignored, cmd_ready=0; accepted only after
//      last transfer + 1 cycle, first new word one cycle after accept.
//   6. resetn low after 2nd of 5 words -> out_valid=0, dout=0, busy=0, cmd_ready=1 after
//      release; fresh command runs correctly from its start.

Source files
------------

// File: rtl/stream_gen.sv
// Arithmetic-sequence stream source: one (start, step, count) command in,
// count words start, start+step, ... out on a valid/ready stream.
module stream_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_start,
  input  logic [DATA_WIDTH-1:0] cmd_step,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_last,
  output logic                  busy
);

  // Handshake rule for both ports: a transfer happens on a rising clk edge
  // where valid && ready are both high; valid-side data is held until then.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] step_r;
  logic [CNT_WIDTH-1:0]  remaining;

  assign cmd_ready = resetn && (state == IDLE);
  assign busy      = (state == RUN);
  assign out_last  = out_valid && (remaining == CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      dout      <= '0;
      step_r    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length command is consumed here without producing output.
          if (cmd_valid && (cmd_count != '0)) begin
            state     <= RUN;
            out_valid <= 1'b1;
            dout      <= cmd_start;
            step_r    <= cmd_step;
            remaining <= cmd_count;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (remaining > CNT_WIDTH'(1)) begin
              dout      <= dout + step_r;
              remaining <= remaining - CNT_WIDTH'(1);
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              remaining <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_gen.sv
// Self-checking bench for stream_gen (8-bit data to exercise wrap arithmetic);
// expected words come from start + i*step computed in plain arithmetic.
module tb_stream_gen;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_start;
  logic [DW-1:0] cmd_step;
  logic [CW-1:0] cmd_count;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          out_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          last_q[$];
  int            hold_bad;
  int            ready_bad;
  logic          pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  stream_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_count(cmd_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_last(out_last), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic build_expected(input logic [DW-1:0] s, input logic [DW-1:0] st, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(int'(s) + i * int'(st)));
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send_cmd(input logic [DW-1:0] s, input logic [DW-1:0] st,
                          input logic [CW-1:0] c, output bit ok);
    int n = 0;
    cmd_start = s; cmd_step = st; cmd_count = c; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = (n < 50);
  endtask

  // Sink: mode 0 always ready, 1 random ready, 2 fixed pattern. Records words,
  // last flags, stall-stability violations and cmd_ready-while-streaming.
  task automatic collect(input int n, input int mode, output int cycles);
    logic          r;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    got_q.delete(); last_q.delete();
    hold_bad = 0; ready_bad = 0; cycles = 0;
    while (got_q.size() < n && cycles < 400) begin
      if (prev_stall && (!out_valid || dout !== prev_d || out_last !== prev_l)) hold_bad++;
      if (out_valid && cmd_ready) ready_bad++;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : pat[cycles % 5];
      out_ready = r;
      if (out_valid && r) begin got_q.push_back(dout); last_q.push_back(out_last); end
      prev_stall = out_valid && !r; prev_d = dout; prev_l = out_last;
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_step = '0; cmd_count = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic run_and_check(input string name, input logic [DW-1:0] s, input logic [DW-1:0] st,
                               input int n, input int mode);
    bit ok;
    int cyc;
    build_expected(s, st, n);
    send_cmd(s, st, CW'(n), ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s accept_timeout", name); end
    collect(n, mode, cyc);
    checks++; if (got_q.size() != n) begin failures++; $display("FAIL %s word_count got=%0d exp=%0d", name, got_q.size(), n); end
    for (int i = 0; i < got_q.size() && i < n; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL %s word[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]); end
      checks++; if (last_q[i] !== (i == n - 1)) begin failures++; $display("FAIL %s last[%0d] got=%b exp=%b", name, i, last_q[i], i == n - 1); end
    end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL %s hold_stability violations=%0d exp=0", name, hold_bad); end
    checks++; if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_last valid=%b cmd_ready=%b busy=%b exp=0,1,0", name, out_valid, cmd_ready, busy);
    end
    if (mode == 0) begin
      checks++; if (cyc != n) begin failures++; $display("FAIL %s consecutive_cycles got=%0d exp=%0d", name, cyc, n); end
    end
  endtask

  task automatic test_basic();
    run_and_check("basic", 8'd5, 8'd2, 3, 0);
  endtask

  task automatic test_backpressure();
    run_and_check("backpressure", 8'd5, 8'd2, 3, 2);
  endtask

  task automatic test_wrap();
    run_and_check("wrap_up", 8'hFE, 8'h01, 4, 0);
    run_and_check("wrap_down", 8'h03, 8'hFF, 3, 0);
  endtask

  task automatic test_count_zero();
    bit ok;
    send_cmd(8'd9, 8'd1, '0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero accept_timeout"); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++; $display("FAIL zero_idle cyc%0d valid=%b busy=%b cmd_ready=%b exp=0,0,1", i, out_valid, busy, cmd_ready);
      end
      @(negedge clk);
    end
    run_and_check("single", 8'd42, 8'd7, 1, 0);
  endtask

  task automatic test_cmd_during_run();
    bit ok;
    int cyc;
    logic [DW-1:0] s2, st2;
    int n2;
    build_expected(8'd20, 8'd3, 4);
    send_cmd(8'd20, 8'd3, CW'(4), ok);
    s2 = DW'($urandom_range(0, 255)); st2 = DW'($urandom_range(0, 255)); n2 = $urandom_range(2, 6);
    cmd_start = s2; cmd_step = st2; cmd_count = CW'(n2); cmd_valid = 1'b1;
    collect(4, 1, cyc);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL overlap first_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL overlap first_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ready_bad != 0) begin failures++; $display("FAIL overlap cmd_ready_in_run count=%0d exp=0", ready_bad); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL overlap ready_after_last got=%b exp=1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== s2) begin
      failures++; $display("FAIL overlap new_first valid=%b dout=%h exp=1,%h", out_valid, dout, s2);
    end
    build_expected(s2, st2, n2);
    collect(n2, 1, cyc);
    checks++; if (got_q.size() != n2) begin failures++; $display("FAIL overlap second_count got=%0d exp=%0d", got_q.size(), n2); end
    for (int i = 0; i < got_q.size() && i < n2; i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL overlap second_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    send_cmd(8'd100, 8'd10, CW'(5), ok);
    collect(2, 0, cyc);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || dout !== '0 || busy !== 1'b0 || out_last !== 1'b0) begin
      failures++; $display("FAIL midreset outputs valid=%b dout=%h busy=%b last=%b exp=0,00,0,0", out_valid, dout, busy, out_last);
    end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL midreset cmd_ready_low got=%b exp=0", cmd_ready); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset release cmd_ready=%b valid=%b exp=1,0", cmd_ready, out_valid);
    end
    run_and_check("after_reset", DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), 5, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++)
      run_and_check($sformatf("rand%0d", k), DW'($urandom_range(0, 255)),
                    DW'($urandom_range(0, 255)), $urandom_range(1, 12), 1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_cmd_during_run();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
